kronos_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two write-back sources:
//  EX direct writes (ALU/CSR results) and LSU load returns.

---
 rtl/kronos_types.sv | 19 +
 rtl/kronos_wb_arb_fsm.sv | 63 ++++++
 rtl/kronos_wb_arbiter.sv | 66 ++++++
 tb/tb_kronos_wb_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_types.sv
// Shared types for the write-back arbiter: request payload and grant-priority state.
package kronos_types;

    // Write-back request payload (destination register and data)
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    // Which source currently holds priority
    typedef enum logic {
        LD_PRI = 1'b0,
        EX_PRI = 1'b1
    } wb_arb_state_e;

    // Load-burst counter width; covers LD_BURST_MAX up to 15
    localparam int BURST_W = 4;

endpackage

// File: rtl/kronos_wb_arb_fsm.sv
// Grant-priority FSM for the write-back port. Loads normally win; after
// LD_BURST_MAX load grants in a row with EX waiting, EX gets one turn.
module kronos_wb_arb_fsm
    import kronos_types::*;
#(
    parameter int LD_BURST_MAX = 4
) (
    input  logic clk,
    input  logic rstz,
    input  logic ex_vld,
    input  logic ld_vld,
    output logic ex_gnt,
    output logic ld_gnt
);

    wb_arb_state_e        state, state_nxt;
    logic [BURST_W-1:0]   burst_cnt, burst_cnt_nxt;

    // State and burst counter registers; flush deliberately has no effect here
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state     <= LD_PRI;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Grant decode and next state; grants depend only on vld and state
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        ex_gnt        = 1'b0;
        ld_gnt        = 1'b0;
        case (state)
            LD_PRI: begin
                ld_gnt = ld_vld;
                ex_gnt = ex_vld && !ld_vld;
                if (ex_gnt || !ex_vld) begin
                    burst_cnt_nxt = '0;
                end else if (ld_gnt) begin
                    burst_cnt_nxt = burst_cnt + BURST_W'(1);
                    // EX has been starved for a full burst: hand it the next slot
                    if (burst_cnt == BURST_W'(LD_BURST_MAX - 1))
                        state_nxt = EX_PRI;
                end
            end
            EX_PRI: begin
                // Load only goes through if EX dropped its request meanwhile
                ex_gnt        = ex_vld;
                ld_gnt        = ld_vld && !ex_vld;
                state_nxt     = LD_PRI;
                burst_cnt_nxt = '0;
            end
            default: begin
                state_nxt     = LD_PRI;
                burst_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/kronos_wb_arbiter.sv
// Write-back arbiter: picks EX or LSU for the single register-file write
// port, registers the winner for one cycle and drives the HCU downgrade.
module kronos_wb_arbiter
    import kronos_types::*;
#(
    parameter int LD_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        flush,
    input  logic        ex_vld,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    output logic        ex_rdy,
    input  logic        ld_vld,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_rdy,
    output logic        regwr_en,
    output logic [4:0]  regwr_sel,
    output logic [31:0] regwr_data,
    output logic        downgrade
);

    logic    ex_gnt, ld_gnt;
    wb_req_t win_req, out_req;
    logic    out_vld, out_nodg;

    kronos_wb_arb_fsm #(
        .LD_BURST_MAX (LD_BURST_MAX)
    ) u_fsm (
        .clk    (clk),
        .rstz   (rstz),
        .ex_vld (ex_vld),
        .ld_vld (ld_vld),
        .ex_gnt (ex_gnt),
        .ld_gnt (ld_gnt)
    );

    assign ex_rdy  = ex_gnt;
    assign ld_rdy  = ld_gnt;
    assign win_req = ld_gnt ? wb_req_t'{rd: ld_rd, data: ld_data}
                            : wb_req_t'{rd: ex_rd, data: ex_data};

    // Output stage; nodg marks writes accepted while the HCU tracker is being cleared
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            out_vld  <= 1'b0;
            out_nodg <= 1'b0;
            out_req  <= '0;
        end else begin
            out_vld  <= ex_gnt || ld_gnt;
            out_nodg <= flush;
            if (ex_gnt || ld_gnt)
                out_req <= win_req;
        end
    end

    // x0 never writes but still downgrades; a flush landing on the output
    // stage suppresses the downgrade of the write already sitting there
    assign regwr_en   = out_vld && (out_req.rd != 5'd0);
    assign regwr_sel  = out_req.rd;
    assign regwr_data = out_req.data;
    assign downgrade  = out_vld && !out_nodg && !flush;

endmodule

// File: tb/tb_kronos_wb_arbiter.sv
module tb_kronos_wb_arbiter;

    typedef struct {
        logic        en;
        logic [4:0]  sel;
        logic [31:0] data;
        logic        dg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        flush = 1'b0;
    logic        ex_vld = 1'b0, ld_vld = 1'b0;
    logic [4:0]  ex_rd = '0, ld_rd = '0;
    logic [31:0] ex_data = '0, ld_data = '0;
    logic        ex_rdy, ld_rdy;
    logic        regwr_en, downgrade;
    logic [4:0]  regwr_sel;
    logic [31:0] regwr_data;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;

    kronos_wb_arbiter #(.LD_BURST_MAX(4)) dut (
        .clk        (clk),
        .rstz       (rstz),
        .flush      (flush),
        .ex_vld     (ex_vld),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .ex_rdy     (ex_rdy),
        .ld_vld     (ld_vld),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_rdy     (ld_rdy),
        .regwr_en   (regwr_en),
        .regwr_sel  (regwr_sel),
        .regwr_data (regwr_data),
        .downgrade  (downgrade)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop/compare last cycle's accepted write, then push this cycle's
    always @(negedge clk) begin
        if (!rstz) begin
            q.delete();
            checks++;
            if (regwr_en !== 1'b0 || downgrade !== 1'b0 || regwr_sel !== 5'd0 || regwr_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs en=%b dg=%b sel=%0d data=%h, want all 0",
                         regwr_en, downgrade, regwr_sel, regwr_data);
            end
        end else begin
            checks++;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (regwr_en !== e.en || regwr_sel !== e.sel || regwr_data !== e.data ||
                    downgrade !== (e.dg && !flush)) begin
                    errors++;
                    $display("FAIL sb_write got en=%b sel=%0d data=%h dg=%b, want en=%b sel=%0d data=%h dg=%b",
                             regwr_en, regwr_sel, regwr_data, downgrade,
                             e.en, e.sel, e.data, e.dg && !flush);
                end
            end else if (regwr_en !== 1'b0 || downgrade !== 1'b0) begin
                errors++;
                $display("FAIL sb_idle got en=%b dg=%b, want 0 0", regwr_en, downgrade);
            end
            checks++;
            if ((ex_rdy && ld_rdy) !== 1'b0) begin
                errors++;
                $display("FAIL rdy_onehot ex_rdy=%b ld_rdy=%b, want at most one", ex_rdy, ld_rdy);
            end
            if (ex_vld && ex_rdy)
                q.push_back('{en: ex_rd != 5'd0, sel: ex_rd, data: ex_data, dg: !flush});
            else if (ld_vld && ld_rdy)
                q.push_back('{en: ld_rd != 5'd0, sel: ld_rd, data: ld_data, dg: !flush});
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string name, input logic ex_w, input logic ld_w);
        checks++;
        if (ex_rdy !== ex_w || ld_rdy !== ld_w) begin
            errors++;
            $display("FAIL %s ex_rdy=%b ld_rdy=%b, want %b %b", name, ex_rdy, ld_rdy, ex_w, ld_w);
        end
    endtask

    task automatic test_reset();
        rstz = 1'b0;
        repeat (2) @(negedge clk);
        chk_rdy("reset_rdy", 1'b0, 1'b0);
        drive_edge();
        rstz = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lone_ex();
        drive_edge();
        ex_vld = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
        @(negedge clk);
        chk_rdy("lone_ex_rdy", 1'b1, 1'b0);
        drive_edge();
        ex_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (regwr_en !== 1'b1 || regwr_sel !== 5'd5 || regwr_data !== 32'hDEADBEEF || downgrade !== 1'b1) begin
            errors++;
            $display("FAIL lone_ex_out en=%b sel=%0d data=%h dg=%b, want 1 5 deadbeef 1",
                     regwr_en, regwr_sel, regwr_data, downgrade);
        end
        @(negedge clk);
        checks++;
        if (regwr_en !== 1'b0 || downgrade !== 1'b0) begin
            errors++;
            $display("FAIL lone_ex_after en=%b dg=%b, want 0 0", regwr_en, downgrade);
        end
    endtask

    task automatic test_both();
        drive_edge();
        ex_vld = 1'b1; ex_rd = 5'd3; ex_data = 32'h0000_0333;
        ld_vld = 1'b1; ld_rd = 5'd4; ld_data = 32'h0000_0444;
        @(negedge clk);
        chk_rdy("both_first_ld", 1'b0, 1'b1);
        drive_edge();
        ld_vld = 1'b0;
        @(negedge clk);
        chk_rdy("both_then_ex", 1'b1, 1'b0);
        drive_edge();
        ex_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_burst();
        int ex_n = 0, ld_n = 0, low_run = 0, low_max = 0;
        logic exp_ex;
        drive_edge();
        ex_vld = 1'b1; ex_rd = 5'd20; ex_data = 32'hE000_0000;
        ld_vld = 1'b1; ld_rd = 5'd10; ld_data = 32'hD000_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_ex = (i % 5 == 4);
            chk_rdy($sformatf("burst_c%0d", i), exp_ex, !exp_ex);
            if (ex_rdy) low_run = 0;
            else begin
                low_run++;
                if (low_run > low_max) low_max = low_run;
            end
            drive_edge();
            if (exp_ex) begin
                ex_n++; ex_rd = 5'(20 + ex_n); ex_data = 32'hE000_0000 + 32'(ex_n);
            end else begin
                ld_n++; ld_rd = 5'(10 + (ld_n % 8)); ld_data = 32'hD000_0000 + 32'(ld_n);
            end
        end
        ex_vld = 1'b0; ld_vld = 1'b0;
        checks++;
        if (low_max > 4) begin
            errors++;
            $display("FAIL burst_starve ex_rdy low %0d cycles, want <= 4", low_max);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive_edge();
        ex_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ex_rd = 5'(i + 1); ex_data = 32'h1234_0000 + 32'(i);
            @(negedge clk);
            chk_rdy($sformatf("b2b_c%0d", i), 1'b1, 1'b0);
            drive_edge();
        end
        ex_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_x0();
        drive_edge();
        ex_vld = 1'b1; ex_rd = 5'd0; ex_data = 32'h0BAD_F00D;
        @(negedge clk);
        chk_rdy("x0_rdy", 1'b1, 1'b0);
        drive_edge();
        ex_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (regwr_en !== 1'b0 || downgrade !== 1'b1 || regwr_sel !== 5'd0) begin
            errors++;
            $display("FAIL x0_out en=%b dg=%b sel=%0d, want 0 1 0", regwr_en, downgrade, regwr_sel);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        // load accepted in the flush cycle
        drive_edge();
        ld_vld = 1'b1; ld_rd = 5'd7; ld_data = 32'h7777_7777; flush = 1'b1;
        @(negedge clk);
        chk_rdy("flush_ld_rdy", 1'b0, 1'b1);
        drive_edge();
        ld_vld = 1'b0; flush = 1'b0;
        ex_vld = 1'b1; ex_rd = 5'd9; ex_data = 32'h9999_9999;
        @(negedge clk);
        checks++;
        if (regwr_en !== 1'b1 || regwr_sel !== 5'd7 || downgrade !== 1'b0) begin
            errors++;
            $display("FAIL flush_accept en=%b sel=%0d dg=%b, want 1 7 0", regwr_en, regwr_sel, downgrade);
        end
        drive_edge();
        ex_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (regwr_sel !== 5'd9 || downgrade !== 1'b1) begin
            errors++;
            $display("FAIL flush_next sel=%0d dg=%b, want 9 1", regwr_sel, downgrade);
        end
        // flush landing while a write sits in the output stage
        drive_edge();
        ld_vld = 1'b1; ld_rd = 5'd8; ld_data = 32'h8888_8888;
        drive_edge();
        ld_vld = 1'b0; flush = 1'b1;
        @(negedge clk);
        checks++;
        if (regwr_en !== 1'b1 || regwr_sel !== 5'd8 || downgrade !== 1'b0) begin
            errors++;
            $display("FAIL flush_outstage en=%b sel=%0d dg=%b, want 1 8 0", regwr_en, regwr_sel, downgrade);
        end
        drive_edge();
        flush = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_edge();
        ex_vld = 1'b1; ex_rd = 5'd11; ex_data = 32'hB0B0_B0B0;
        ld_vld = 1'b1; ld_rd = 5'd12; ld_data = 32'hC0C0_C0C0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_rdy($sformatf("rmid_ld%0d", i), 1'b0, 1'b1);
            drive_edge();
            ld_data = ld_data + 32'd1;
        end
        @(negedge clk);
        chk_rdy("rmid_ex", 1'b1, 1'b0);
        #2;
        rstz = 1'b0;
        ex_vld = 1'b0; ld_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (regwr_en !== 1'b0 || downgrade !== 1'b0) begin
            errors++;
            $display("FAIL rmid_pulse en=%b dg=%b, want 0 0", regwr_en, downgrade);
        end
        drive_edge();
        rstz = 1'b1;
        @(negedge clk);
        // both requesting right after reset: LD_PRI means the load wins
        drive_edge();
        ex_vld = 1'b1; ex_rd = 5'd13; ex_data = 32'h1313_1313;
        ld_vld = 1'b1; ld_rd = 5'd14; ld_data = 32'h1414_1414;
        @(negedge clk);
        chk_rdy("rmid_ldpri", 1'b0, 1'b1);
        drive_edge();
        ld_vld = 1'b0;
        @(negedge clk);
        chk_rdy("rmid_ex_after", 1'b1, 1'b0);
        drive_edge();
        ex_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lone_ex();
        test_both();
        test_burst();
        test_back_to_back();
        test_x0();
        test_flush();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain %0d writes never retired, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
